// File: rtl/pipe_stage_buf_if.sv
// Handshake bundle for one pipe_stage_buf instance.
//
// Carries the upstream side (in_*) and the downstream side (out_*) of the
// stage register. Both sides follow the same valid/ready rule:
//   an entry moves on a rising clk edge where valid and ready are both 1;
//   valid, ctrl and data must not change until that edge; ready may change
//   freely and never depends on the same side's valid having risen first.
//
// Modports:
//   slave  - the stage buffer: consumes in_*, produces out_*.
//   master - the surrounding stages: produce in_*, consume out_*.
interface pipe_stage_buf_if #(
  parameter int CTRL_W = 4,
  parameter int DATA_W = 69
);
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;

  modport slave (
    input  in_valid, in_ctrl, in_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_data
  );

  modport master (
    output in_valid, in_ctrl, in_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data
  );
endinterface

// File: rtl/pipe_stage_buf.sv
// Generic inter-stage pipeline register with optional 2-entry skid buffer.
//
// Holds a control field (forced to zero whenever no valid entry is shown,
// so a bubble can never fire a write-enable) and a payload field (held as
// is across bubbles). Adds flush, a global freeze and a saturating counter
// of cycles in which a valid output was not taken.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous reset, active-low
//   bus          pipe_stage_buf_if.slave: in_valid/in_ready/in_ctrl/in_data
//                from upstream, out_valid/out_ready/out_ctrl/out_data to
//                downstream
//   flush        discard every held entry (wins over freeze)
//   freeze       hold all state, no transfers in either direction
//   clr_cnt      synchronous clear of stall_cnt (wins over an increment)
//   stall_cnt    cycles with out_valid=1 and no output transfer, saturating
//   dbg_state_o  current occupancy state (0 EMPTY, 1 ONE, 2 TWO)
//
// Parameters:
//   CTRL_W, DATA_W  field widths (must match the interface instance)
//   SKID            1: skid entry + registered in_ready
//                   0: single entry, in_ready combinational from out_ready
//   CNT_W           stall counter width
module pipe_stage_buf #(
  parameter int CTRL_W = 4,
  parameter int DATA_W = 69,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  pipe_stage_buf_if.slave     bus,
  input  logic                flush,
  input  logic                freeze,
  input  logic                clr_cnt,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [1:0]          dbg_state_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [CTRL_W-1:0] out_ctrl_q, out_ctrl_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              in_ready_q, in_ready_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic in_ready;
  logic in_xfer;
  logic out_xfer;

  // in_ready. With the skid entry it comes from a register that looks only
  // at the next state, never at out_ready. Freeze gates it directly so the
  // upstream side never sees a handshake that the buffer then ignores.
  // Without the skid entry the single register can be refilled in the same
  // cycle it drains, so out_ready is passed through.
  always_comb begin
    if (SKID != 0) begin
      in_ready = in_ready_q & ~freeze;
    end else begin
      in_ready = rst & ~freeze & (~out_valid_q | bus.out_ready);
    end
  end

  assign in_xfer  = bus.in_valid & in_ready;
  assign out_xfer = out_valid_q & bus.out_ready & ~freeze;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_ctrl_d  = out_ctrl_q;
    out_data_d  = out_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;

    if (flush) begin
      // out_data is deliberately kept; any same-cycle input is dropped.
      state_d     = EMPTY;
      out_valid_d = 1'b0;
      skid_ctrl_d = '0;
    end else if (!freeze) begin
      unique case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            state_d     = ONE;
            out_valid_d = 1'b1;
            out_ctrl_d  = bus.in_ctrl;
            out_data_d  = bus.in_data;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            out_ctrl_d = bus.in_ctrl;
            out_data_d = bus.in_data;
          end else if (in_xfer) begin
            // Only reachable with SKID=1: without a skid entry in_ready
            // already requires out_ready while out_valid is high.
            state_d     = TWO;
            skid_ctrl_d = bus.in_ctrl;
            skid_data_d = bus.in_data;
          end else if (out_xfer) begin
            state_d     = EMPTY;
            out_valid_d = 1'b0;
          end
        end
        TWO: begin
          if (out_xfer) begin
            state_d     = ONE;
            out_ctrl_d  = skid_ctrl_q;
            out_data_d  = skid_data_q;
            skid_ctrl_d = '0;
          end
        end
        default: begin
          state_d     = EMPTY;
          out_valid_d = 1'b0;
        end
      endcase
    end

    // A bubble must never carry live control bits.
    if (!out_valid_d) begin
      out_ctrl_d = '0;
    end
  end

  assign in_ready_d = (state_d != TWO);

  // Stall counter: saturates at all-ones, clear wins, flush does not touch it.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (out_valid_q && !out_xfer && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= EMPTY;
      out_valid_q <= 1'b0;
      out_ctrl_q  <= '0;
      out_data_q  <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      in_ready_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_ctrl_q  <= out_ctrl_d;
      out_data_q  <= out_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      in_ready_q  <= in_ready_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_ctrl  = out_ctrl_q;
  assign bus.out_data  = out_data_q;
  assign stall_cnt     = cnt_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
module tb_pipe_stage_buf;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // DUT A: default parameters (SKID=1, CNT_W=16)
  pipe_stage_buf_if #(.CTRL_W(4), .DATA_W(69)) bus_a ();
  logic        flush_a = 1'b0, freeze_a = 1'b0, clr_a = 1'b0;
  logic [15:0] stall_a;
  logic [1:0]  state_a;

  pipe_stage_buf #(.CTRL_W(4), .DATA_W(69), .SKID(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .flush(flush_a), .freeze(freeze_a),
    .clr_cnt(clr_a), .stall_cnt(stall_a), .dbg_state_o(state_a)
  );

  // DUT B: SKID=0, 4-bit counter
  pipe_stage_buf_if #(.CTRL_W(4), .DATA_W(8)) bus_b ();
  logic       flush_b = 1'b0, freeze_b = 1'b0, clr_b = 1'b0;
  logic [3:0] stall_b;
  logic [1:0] state_b;

  pipe_stage_buf #(.CTRL_W(4), .DATA_W(8), .SKID(0), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .flush(flush_b), .freeze(freeze_b),
    .clr_cnt(clr_b), .stall_cnt(stall_b), .dbg_state_o(state_b)
  );

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [3:0] c, input logic [68:0] d);
    bus_a.in_valid = v;
    bus_a.in_ctrl  = c;
    bus_a.in_data  = d;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst = 1'b0;
    drive_a(1'b1, 4'hF, 69'h55);
    bus_a.out_ready = 1'b1;
    bus_b.in_valid = 1'b1; bus_b.in_ctrl = 4'hF; bus_b.in_data = 8'h55;
    bus_b.out_ready = 1'b1;
    repeat (3) tick();
    tests_run++; if (bus_a.out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %0b want 0", bus_a.out_valid); end
    tests_run++; if (bus_a.out_ctrl !== 4'h0) begin tests_failed++; $display("FAIL reset_out_ctrl got %0h want 0", bus_a.out_ctrl); end
    tests_run++; if (bus_a.out_data !== 69'h0) begin tests_failed++; $display("FAIL reset_out_data got %0h want 0", bus_a.out_data); end
    tests_run++; if (stall_a !== 16'd0) begin tests_failed++; $display("FAIL reset_stall got %0d want 0", stall_a); end
    tests_run++; if (bus_a.in_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_in_ready_a got %0b want 0", bus_a.in_ready); end
    tests_run++; if (bus_b.in_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_in_ready_b got %0b want 0", bus_b.in_ready); end
    tests_run++; if (state_a !== 2'd0) begin tests_failed++; $display("FAIL reset_state got %0d want 0", state_a); end
    rst = 1'b1;
    drive_a(1'b0, 4'h0, 69'h0);
    bus_b.in_valid = 1'b0;
    tick();
    tests_run++; if (bus_a.in_ready !== 1'b1) begin tests_failed++; $display("FAIL release_in_ready_a got %0b want 1", bus_a.in_ready); end
    tests_run++; if (bus_b.in_ready !== 1'b1) begin tests_failed++; $display("FAIL release_in_ready_b got %0b want 1", bus_b.in_ready); end
    tests_run++; if (bus_a.out_valid !== 1'b0) begin tests_failed++; $display("FAIL release_out_valid got %0b want 0", bus_a.out_valid); end
  endtask

  task automatic test_streaming;
    bus_a.out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      drive_a(1'b1, 4'hA, 69'(i));
      tick();
      tests_run++; if (bus_a.out_valid !== 1'b1 || bus_a.out_data !== 69'(i) || bus_a.out_ctrl !== 4'hA)
        begin tests_failed++; $display("FAIL stream_out[%0d] got v=%0b c=%0h d=%0h want v=1 c=a d=%0h", i, bus_a.out_valid, bus_a.out_ctrl, bus_a.out_data, i); end
      tests_run++; if (bus_a.in_ready !== 1'b1) begin tests_failed++; $display("FAIL stream_in_ready[%0d] got %0b want 1", i, bus_a.in_ready); end
    end
    drive_a(1'b0, 4'h0, 69'h0);
    tick();
    tests_run++; if (bus_a.out_valid !== 1'b0 || bus_a.out_ctrl !== 4'h0) begin tests_failed++; $display("FAIL stream_drain got v=%0b c=%0h want v=0 c=0", bus_a.out_valid, bus_a.out_ctrl); end
    tests_run++; if (bus_a.out_data !== 69'd3) begin tests_failed++; $display("FAIL stream_data_held got %0h want 3", bus_a.out_data); end
    tests_run++; if (stall_a !== 16'd0) begin tests_failed++; $display("FAIL stream_stall got %0d want 0", stall_a); end
  endtask

  task automatic test_backpressure;
    bus_a.out_ready = 1'b0;
    drive_a(1'b1, 4'h3, 69'd5);
    tick();
    tests_run++; if (bus_a.out_data !== 69'd5 || bus_a.out_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_first got v=%0b d=%0h want v=1 d=5", bus_a.out_valid, bus_a.out_data); end
    tests_run++; if (bus_a.in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_ready_one got %0b want 1", bus_a.in_ready); end
    drive_a(1'b1, 4'h3, 69'd6);
    tick();
    tests_run++; if (bus_a.in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_ready_two got %0b want 0", bus_a.in_ready); end
    tests_run++; if (state_a !== 2'd2) begin tests_failed++; $display("FAIL bp_state_two got %0d want 2", state_a); end
    drive_a(1'b1, 4'h3, 69'd7);
    tick();
    tests_run++; if (bus_a.out_data !== 69'd5 || bus_a.in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_hold got d=%0h rdy=%0b want d=5 rdy=0", bus_a.out_data, bus_a.in_ready); end
    tests_run++; if (stall_a !== 16'd2) begin tests_failed++; $display("FAIL bp_stall_mid got %0d want 2", stall_a); end
    bus_a.out_ready = 1'b1;
    tick();
    tests_run++; if (bus_a.out_data !== 69'd6 || bus_a.out_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_second got v=%0b d=%0h want v=1 d=6", bus_a.out_valid, bus_a.out_data); end
    tests_run++; if (bus_a.in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_ready_back got %0b want 1", bus_a.in_ready); end
    tick();
    tests_run++; if (bus_a.out_data !== 69'd7 || bus_a.out_valid !== 1'b1 || bus_a.out_ctrl !== 4'h3) begin tests_failed++; $display("FAIL bp_third got v=%0b c=%0h d=%0h want v=1 c=3 d=7", bus_a.out_valid, bus_a.out_ctrl, bus_a.out_data); end
    drive_a(1'b0, 4'h0, 69'h0);
    tick();
    tests_run++; if (bus_a.out_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_empty got %0b want 0", bus_a.out_valid); end
    tests_run++; if (stall_a !== 16'd2) begin tests_failed++; $display("FAIL bp_stall_total got %0d want 2", stall_a); end
  endtask

  task automatic test_flush;
    bus_a.out_ready = 1'b0;
    drive_a(1'b1, 4'h9, 69'd8);
    tick();
    drive_a(1'b1, 4'h9, 69'd9);
    tick();
    tests_run++; if (state_a !== 2'd2) begin tests_failed++; $display("FAIL flush_setup_state got %0d want 2", state_a); end
    flush_a = 1'b1;
    drive_a(1'b1, 4'h9, 69'd10);
    tick();
    flush_a = 1'b0;
    tests_run++; if (bus_a.out_valid !== 1'b0 || bus_a.out_ctrl !== 4'h0) begin tests_failed++; $display("FAIL flush_out got v=%0b c=%0h want v=0 c=0", bus_a.out_valid, bus_a.out_ctrl); end
    tests_run++; if (bus_a.out_data !== 69'd8) begin tests_failed++; $display("FAIL flush_data_held got %0h want 8", bus_a.out_data); end
    tests_run++; if (state_a !== 2'd0) begin tests_failed++; $display("FAIL flush_state got %0d want 0", state_a); end
    tests_run++; if (stall_a !== 16'd4) begin tests_failed++; $display("FAIL flush_stall got %0d want 4", stall_a); end
    bus_a.out_ready = 1'b1;
    drive_a(1'b1, 4'h6, 69'd12);
    tick();
    tests_run++; if (bus_a.out_valid !== 1'b1 || bus_a.out_data !== 69'd12 || bus_a.out_ctrl !== 4'h6) begin tests_failed++; $display("FAIL flush_next got v=%0b c=%0h d=%0h want v=1 c=6 d=c", bus_a.out_valid, bus_a.out_ctrl, bus_a.out_data); end
    drive_a(1'b0, 4'h0, 69'h0);
    tick();
    tests_run++; if (bus_a.out_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_no_ghost got %0b want 0", bus_a.out_valid); end
  endtask

  task automatic test_freeze;
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    tests_run++; if (stall_a !== 16'd0) begin tests_failed++; $display("FAIL clr_a got %0d want 0", stall_a); end
    bus_a.out_ready = 1'b1;
    drive_a(1'b1, 4'h5, 69'd11);
    tick();
    drive_a(1'b0, 4'h0, 69'h0);
    freeze_a = 1'b1;
    #1;
    tests_run++; if (bus_a.in_ready !== 1'b0) begin tests_failed++; $display("FAIL freeze_in_ready_now got %0b want 0", bus_a.in_ready); end
    for (int i = 0; i < 4; i++) begin
      tick();
      tests_run++; if (bus_a.out_data !== 69'd11 || bus_a.out_valid !== 1'b1 || bus_a.in_ready !== 1'b0)
        begin tests_failed++; $display("FAIL freeze_hold[%0d] got v=%0b d=%0h rdy=%0b want v=1 d=b rdy=0", i, bus_a.out_valid, bus_a.out_data, bus_a.in_ready); end
    end
    tests_run++; if (stall_a !== 16'd4) begin tests_failed++; $display("FAIL freeze_stall got %0d want 4", stall_a); end
    freeze_a = 1'b0;
    tick();
    tests_run++; if (bus_a.out_valid !== 1'b0) begin tests_failed++; $display("FAIL freeze_release got %0b want 0", bus_a.out_valid); end
    tests_run++; if (stall_a !== 16'd4) begin tests_failed++; $display("FAIL freeze_stall_after got %0d want 4", stall_a); end
  endtask

  task automatic test_saturation;
    bus_b.out_ready = 1'b0;
    bus_b.in_valid = 1'b1; bus_b.in_ctrl = 4'h1; bus_b.in_data = 8'h21;
    tick();
    bus_b.in_valid = 1'b0;
    tests_run++; if (bus_b.out_data !== 8'h21 || bus_b.out_valid !== 1'b1) begin tests_failed++; $display("FAIL sat_load got v=%0b d=%0h want v=1 d=21", bus_b.out_valid, bus_b.out_data); end
    repeat (20) tick();
    tests_run++; if (stall_b !== 4'd15) begin tests_failed++; $display("FAIL sat_value got %0d want 15", stall_b); end
    tests_run++; if (bus_b.in_ready !== 1'b0) begin tests_failed++; $display("FAIL sat_in_ready got %0b want 0", bus_b.in_ready); end
    clr_b = 1'b1;
    tick();
    clr_b = 1'b0;
    tests_run++; if (stall_b !== 4'd0) begin tests_failed++; $display("FAIL sat_clr_wins got %0d want 0", stall_b); end
    tick();
    tests_run++; if (stall_b !== 4'd1) begin tests_failed++; $display("FAIL sat_resume got %0d want 1", stall_b); end
    bus_b.out_ready = 1'b1;
    tick();
    tests_run++; if (bus_b.out_valid !== 1'b0 || bus_b.out_ctrl !== 4'h0) begin tests_failed++; $display("FAIL sat_drain got v=%0b c=%0h want v=0 c=0", bus_b.out_valid, bus_b.out_ctrl); end
  endtask

  task automatic test_skid0_stream;
    logic [7:0] exp_q[$];
    logic       m_valid = 1'b0;
    logic       in_hs, out_hs, exp_rdy;
    int         sent = 0, got = 0;
    for (int c = 0; c < 30; c++) begin
      bus_b.out_ready = c[0];
      bus_b.in_valid  = (sent < 6);
      bus_b.in_ctrl   = 4'h7;
      bus_b.in_data   = 8'h30 + 8'(sent);
      #1;
      exp_rdy = ~m_valid | bus_b.out_ready;
      tests_run++; if (bus_b.in_ready !== exp_rdy) begin tests_failed++; $display("FAIL s0_in_ready[c%0d] got %0b want %0b", c, bus_b.in_ready, exp_rdy); end
      in_hs  = bus_b.in_valid & bus_b.in_ready;
      out_hs = bus_b.out_valid & bus_b.out_ready;
      if (out_hs) begin
        tests_run++;
        if (exp_q.size() == 0) begin tests_failed++; $display("FAIL s0_extra got %0h want none", bus_b.out_data); end
        else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (bus_b.out_data !== e || bus_b.out_ctrl !== 4'h7) begin tests_failed++; $display("FAIL s0_data got c=%0h d=%0h want c=7 d=%0h", bus_b.out_ctrl, bus_b.out_data, e); end
        end
        got++;
      end
      if (in_hs) begin
        exp_q.push_back(bus_b.in_data);
        sent++;
      end
      m_valid = (m_valid & ~out_hs) | in_hs;
      tick();
      tests_run++; if (bus_b.out_valid !== m_valid) begin tests_failed++; $display("FAIL s0_out_valid[c%0d] got %0b want %0b", c, bus_b.out_valid, m_valid); end
    end
    bus_b.in_valid = 1'b0;
    tests_run++; if (got !== 6 || exp_q.size() != 0) begin tests_failed++; $display("FAIL s0_count got %0d want 6 (left %0d)", got, exp_q.size()); end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "timeout");
  end

  // ---------------- sequence / report ----------------
  initial begin
    drive_a(1'b0, 4'h0, 69'h0);
    bus_a.out_ready = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_ctrl = 4'h0; bus_b.in_data = 8'h0;
    bus_b.out_ready = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_freeze();
    test_saturation();
    test_skid0_stream();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Generic, parametrised inter-stage pipeline register; next generation of the fixed-field stage registers (ID/EX, EX/MEM, MEM/WB).
- Carries a control field that is zeroed on bubbles and a data field that is not.
- Uses a valid/ready handshake with an optional 2-entry skid buffer, plus flush, legacy freeze and a saturating stall-cycle counter.
- Sits between any two pipeline stages; stage wrappers concatenate their signals into in_ctrl/in_data.

Parameters:
- CTRL_W, 4: control bits (WB_en, MEM_R_EN, …); forced to 0 whenever the output is not valid.
- DATA_W, 69: payload bits (ALU result, read value, dest, …); held unchanged when not valid.
- SKID, 1: 1 gives a 2-entry skid buffer with registered in_ready; 0 gives a single entry with combinational in_ready.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-low
- in_valid  in  1  upstream entry valid
- in_ready  out  1  block can accept this cycle
- in_ctrl  in  CTRL_W  upstream control field
- in_data  in  DATA_W  upstream payload
- flush  in  1  discard all held entries
- freeze  in  1  hold everything; no transfers
- out_valid  out  1  output entry valid
- out_ready  in  1  downstream accepts
- out_ctrl  out  CTRL_W  registered control; 0 when out_valid=0
- out_data  out  DATA_W  registered payload
- stall_cnt  out  CNT_W  cycles with out_valid=1 and no output transfer
- clr_cnt  in  1  synchronous clear of stall_cnt

Behaviour:
- Reset (rst=0 at a clk edge): out_valid=0, out_ctrl=0, out_data=0, skid entry invalid and zeroed, stall_cnt=0, state EMPTY. in_ready=0 while rst=0. First cycle after release: in_ready=1.
- Transfers: input transfer = in_valid & in_ready. Output transfer = out_valid & out_ready & ~freeze.
- Latency: an accepted entry appears on out_* the next cycle.
- Ordering: strict FIFO, no loss, no duplication.
- States (SKID=1):
  - EMPTY: input transfer loads out regs -> ONE.
  - ONE, input and output transfer together: new entry loads out regs, stay ONE.
  - ONE, input only: entry goes to skid reg -> TWO.
  - ONE, output only: -> EMPTY.
  - TWO: output transfer moves skid to out -> ONE. No input is accepted in TWO.
- in_ready (SKID=1): registered; equals 1 in EMPTY or ONE, 0 in TWO, 0 while freeze=1. Not a function of out_ready.
- SKID=0: states EMPTY and ONE only; in_ready = ~freeze & (~out_valid | out_ready), combinational.
- freeze=1: no input or output transfer. All registers hold. stall_cnt still counts when out_valid=1.
- flush=1: next cycle state=EMPTY, out_valid=0, out_ctrl=0, skid invalid. out_data is held. Any input handshake in the flush cycle is discarded.
- Priority: rst > flush > freeze > normal operation.
- out_ctrl rule: whenever out_valid is 0, out_ctrl is 0 (bubble kills write-enables).
- stall_cnt:
  - +1 on each cycle with out_valid=1 and no output transfer.
  - Saturates at 2^CNT_W-1; no wrap.
  - clr_cnt=1 sets it to 0 and wins over a same-cycle increment.
  - Unaffected by flush.
- All outputs are registered except SKID=0 in_ready.

Test Plan:
- Reset: hold rst=0 for 3 cycles with in_valid=1 -> out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0, in_ready=0; the cycle after release, in_ready=1.
- Streaming: out_ready=1, send ctrl=4'hA/data=1,2,3 on consecutive cycles -> out_* show 1,2,3 on cycles +1,+2,+3 with out_ctrl=4'hA; in_ready stays 1.
- Backpressure (SKID=1): out_ready=0, send entries 5,6,7 -> 5 on out, 6 in skid, in_ready=0 from the cycle after 6 is accepted, 7 held upstream; raise out_ready -> out sequence 5,6,7, stall_cnt equals the number of blocked cycles.
- Flush: state TWO (entries 8,9) with flush=1 and in_valid=1 data=10 -> next cycle out_valid=0, out_ctrl=0, out_data still 8, entry 10 lost; the next input appears normally.
- Freeze: out_valid=1 data=11, out_ready=1, freeze=1 for 4 cycles -> out_data stays 11, in_ready=0, stall_cnt +4; freeze=0 -> 11 transfers.
- Saturation and SKID=0: CNT_W=4, stall 20 cycles -> stall_cnt=15; clr_cnt together with a stall -> 0. SKID=0 streaming with out_ready toggling every cycle -> in_ready tracks ~out_valid|out_ready combinationally, no entry lost.
